// File: rtl/pc_fetch_controller.sv
// rtl/pc_fetch_controller.sv - IF-stage program counter sequencer with redirect bubbles and halt
//
// Purpose: selects the next word-addressed fetch PC each cycle from PC+1, the EX branch
// target or the ID jump target. It applies hazard stalls, inserts BUBBLES non-fetching
// cycles after a redirect, drives the IF/ID flush and supports a terminal halt.
//
// Optional build macro: PC_PERF_COUNTERS_EN adds saturating fetch/redirect counters.
//
// Ports:
//   i_clk            clock, all state updates on the rising edge
//   i_reset          asynchronous active-high reset
//   i_stall          hazard unit stall: hold PC, no fetch
//   i_branch_taken   taken branch resolved in EX
//   i_branch_target  branch target word address
//   i_jump           jump decoded in ID
//   i_jump_target    jump target word address
//   i_halt           halt reached: stop fetching until reset
//   o_pc             current fetch address (registered)
//   o_pc_plus1       o_pc + 1 (mod 2^32)
//   o_fetch_valid    instruction memory output at o_pc is a valid fetch
//   o_flush_ifid     IF/ID register loads a bubble this cycle
//   o_ctrl_state     FSM state for debug (0 boot, 1 run, 2 redirect, 3 halt)
//   o_fetch_count    (PC_PERF_COUNTERS_EN) cycles with o_fetch_valid=1, saturating
//   o_redirect_count (PC_PERF_COUNTERS_EN) accepted redirects, saturating

module pc_fetch_controller #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          BUBBLES  = 1
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_stall,
   input  logic        i_branch_taken,
   input  logic [31:0] i_branch_target,
   input  logic        i_jump,
   input  logic [31:0] i_jump_target,
   input  logic        i_halt,
   output logic [31:0] o_pc,
   output logic [31:0] o_pc_plus1,
   output logic        o_fetch_valid,
   output logic        o_flush_ifid,
`ifdef PC_PERF_COUNTERS_EN
   output logic [31:0] o_fetch_count,
   output logic [15:0] o_redirect_count,
`endif
   output logic [1:0]  o_ctrl_state
);

   typedef enum logic [1:0] {
      S_BOOT  = 2'd0,
      S_RUN   = 2'd1,
      S_REDIR = 2'd2,
      S_HALT  = 2'd3
   } state_t;

   // Counter holds bubbles remaining after the current one, so the reload is BUBBLES-1.
   localparam logic [2:0] LP_RELOAD = (BUBBLES == 0) ? 3'd0 : 3'(BUBBLES - 1);

   state_t      r_state;
   logic [31:0] r_pc;
   logic [2:0]  r_cnt;

   state_t      w_state_next;
   logic [31:0] w_pc_next;
   logic [2:0]  w_cnt_next;
   logic        w_fetch_valid;
   logic        w_redirect;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state <= S_BOOT;
         r_pc    <= RESET_PC;
         r_cnt   <= 3'd0;
      end else begin
         r_state <= w_state_next;
         r_pc    <= w_pc_next;
         r_cnt   <= w_cnt_next;
      end
   end

   always_comb begin
      w_state_next  = r_state;
      w_pc_next     = r_pc;
      w_cnt_next    = r_cnt;
      w_fetch_valid = 1'b0;
      w_redirect    = 1'b0;

      case (r_state)
         S_BOOT: begin
            w_state_next = S_RUN;
         end

         S_RUN: begin
            w_fetch_valid = ~i_stall;
            // Branch is the older instruction, so it wins over the jump; any
            // redirect also wins over a stall because the stalled slot is flushed.
            if (i_branch_taken) begin
               w_pc_next  = i_branch_target;
               w_redirect = 1'b1;
            end else if (i_jump) begin
               w_pc_next  = i_jump_target;
               w_redirect = 1'b1;
            end else if (i_halt) begin
               w_state_next = S_HALT;
            end else if (!i_stall) begin
               w_pc_next = r_pc + 32'd1;
            end

            if (w_redirect && (BUBBLES != 0)) begin
               w_state_next = S_REDIR;
               w_cnt_next   = LP_RELOAD;
            end
         end

         S_REDIR: begin
            // Jump/halt seen here belong to already-flushed younger instructions.
            if (i_branch_taken) begin
               w_pc_next  = i_branch_target;
               w_redirect = 1'b1;
               w_cnt_next = LP_RELOAD;
            end else if (r_cnt == 3'd0) begin
               w_state_next = S_RUN;
            end else begin
               w_cnt_next = r_cnt - 3'd1;
            end
         end

         default: begin
            // S_HALT: frozen until reset.
         end
      endcase
   end

   assign o_pc          = r_pc;
   assign o_pc_plus1    = r_pc + 32'd1;
   assign o_fetch_valid = w_fetch_valid;
   assign o_flush_ifid  = w_redirect;
   assign o_ctrl_state  = r_state;

`ifdef PC_PERF_COUNTERS_EN
   logic [31:0] r_fetch_count;
   logic [15:0] r_redirect_count;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_fetch_count    <= 32'd0;
         r_redirect_count <= 16'd0;
      end else begin
         if (w_fetch_valid && (r_fetch_count != 32'hFFFF_FFFF)) begin
            r_fetch_count <= r_fetch_count + 32'd1;
         end
         if (w_redirect && (r_redirect_count != 16'hFFFF)) begin
            r_redirect_count <= r_redirect_count + 16'd1;
         end
      end
   end

   assign o_fetch_count    = r_fetch_count;
   assign o_redirect_count = r_redirect_count;
`endif

endmodule

// File: tb/tb_pc_fetch_controller.sv
// tb/tb_pc_fetch_controller.sv - self-checking bench for pc_fetch_controller

module tb_pc_fetch_controller;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          BUBBLES  = 1;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        jump;
   logic [31:0] jump_target;
   logic        halt;
   logic [31:0] pc;
   logic [31:0] pc_plus1;
   logic        fetch_valid;
   logic        flush_ifid;
   logic [1:0]  ctrl_state;
`ifdef PC_PERF_COUNTERS_EN
   logic [31:0] fetch_count;
   logic [15:0] redirect_count;
`endif

   int checks   = 0;
   int failures = 0;

   // Reference model: abstract machine state, not the RTL encoding.
   logic [31:0] m_pc;
   bit          m_booting;
   bit          m_halted;
   int          m_bubbles_left;
   longint      m_fetches;
   longint      m_redirects;

   pc_fetch_controller #(
      .RESET_PC(RESET_PC),
      .BUBBLES (BUBBLES)
   ) dut (
      .i_clk           (clk),
      .i_reset         (reset),
      .i_stall         (stall),
      .i_branch_taken  (branch_taken),
      .i_branch_target (branch_target),
      .i_jump          (jump),
      .i_jump_target   (jump_target),
      .i_halt          (halt),
      .o_pc            (pc),
      .o_pc_plus1      (pc_plus1),
      .o_fetch_valid   (fetch_valid),
      .o_flush_ifid    (flush_ifid),
`ifdef PC_PERF_COUNTERS_EN
      .o_fetch_count   (fetch_count),
      .o_redirect_count(redirect_count),
`endif
      .o_ctrl_state    (ctrl_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc           = RESET_PC;
      m_booting      = 1'b1;
      m_halted       = 1'b0;
      m_bubbles_left = 0;
      m_fetches      = 0;
      m_redirects    = 0;
   endtask

   // Called at posedge+1; applies inputs, checks at posedge+4, advances the model at the edge.
   task automatic step(input bit s, input bit b, input logic [31:0] bt,
                       input bit j, input logic [31:0] jt, input bit h);
      bit          e_fv;
      bit          e_flush;
      logic [31:0] e_state;
      stall = s; branch_taken = b; branch_target = bt; jump = j; jump_target = jt; halt = h;
      #3;
      e_fv    = !m_booting && !m_halted && (m_bubbles_left == 0) && !s;
      e_flush = !m_booting && !m_halted && (b || ((m_bubbles_left == 0) && j));
      if (m_booting)               e_state = 32'd0;
      else if (m_halted)           e_state = 32'd3;
      else if (m_bubbles_left > 0) e_state = 32'd2;
      else                         e_state = 32'd1;
      chk("pc", pc, m_pc);
      chk("pc_plus1", pc_plus1, m_pc + 32'd1);
      chk("fetch_valid", {31'd0, fetch_valid}, {31'd0, e_fv});
      chk("flush_ifid", {31'd0, flush_ifid}, {31'd0, e_flush});
      chk("ctrl_state", {30'd0, ctrl_state}, e_state);
`ifdef PC_PERF_COUNTERS_EN
      chk("fetch_count", fetch_count, 32'(m_fetches));
      chk("redirect_count", {16'd0, redirect_count}, 32'(m_redirects));
`endif
      if (e_fv) m_fetches++;
      if (e_flush) m_redirects++;
      if (m_booting) begin
         m_booting = 1'b0;
      end else if (m_halted) begin
         // frozen
      end else if (m_bubbles_left > 0) begin
         if (b) begin
            m_pc = bt;
            m_bubbles_left = BUBBLES;
         end else begin
            m_bubbles_left--;
         end
      end else if (b) begin
         m_pc = bt;
         m_bubbles_left = BUBBLES;
      end else if (j) begin
         m_pc = jt;
         m_bubbles_left = BUBBLES;
      end else if (h) begin
         m_halted = 1'b1;
      end else if (!s) begin
         m_pc = m_pc + 32'd1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
   endtask

   // Asynchronous reset asserted mid-cycle, checked before any clock edge.
   task automatic do_reset();
      #1;
      reset = 1'b1;
      #1;
      chk("rst_pc", pc, RESET_PC);
      chk("rst_state", {30'd0, ctrl_state}, 32'd0);
      chk("rst_fv", {31'd0, fetch_valid}, 32'd0);
      chk("rst_flush", {31'd0, flush_ifid}, 32'd0);
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      int guard;
      reset = 1'b1; stall = 0; branch_taken = 0; branch_target = 0;
      jump = 0; jump_target = 0; halt = 0;
      model_reset();
      @(posedge clk);
      #1;
      do_reset();

      // Boot then sequential fetch
      for (int i = 0; i < 5; i++) idle();
      guard = 0;
      while (m_pc != 32'd5 && guard < 20) begin idle(); guard++; end
      chk("reach_pc5", pc, 32'd5);

      // Stall three cycles at PC=5
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
      chk("after_stall_pc", pc, 32'd5);
      idle();
      chk("stall_release_pc", pc, 32'd6);

      // Branch + jump + stall together: branch wins
      step(1'b1, 1'b1, 32'h40, 1'b1, 32'h80, 1'b0);
      chk("branch_target_pc", pc, 32'h40);
      idle();
      idle();
      chk("branch_advance_pc", pc, 32'h41);

      // PC wrap at all-ones
      step(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'd0, 1'b0);
      idle();
      chk("wrap_plus1", pc_plus1, 32'd0);
      idle();
      chk("wrap_pc", pc, 32'd0);

      // Halt at 0x10 with jump pulses ignored
      step(1'b0, 1'b0, 32'd0, 1'b1, 32'h10, 1'b0);
      idle();
      step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
      for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 32'd0, i[0], 32'h999, 1'b0);
      chk("halt_pc", pc, 32'h10);
      chk("halt_fv", {31'd0, fetch_valid}, 32'd0);
      do_reset();

`ifdef PC_PERF_COUNTERS_EN
      idle();
      for (int i = 0; i < 10; i++) idle();
      step(1'b1, 1'b1, 32'h200, 1'b0, 32'd0, 1'b0);
      step(1'b0, 1'b1, 32'h300, 1'b0, 32'd0, 1'b0);
      step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
      chk("perf_fetch", fetch_count, 32'd10);
      chk("perf_redirect", {16'd0, redirect_count}, 32'd2);
      do_reset();
`endif

      // Randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         if (i % 97 == 96) begin
            do_reset();
         end else begin
            step($urandom_range(0, 3) == 0,
                 $urandom_range(0, 9) == 0, $urandom,
                 $urandom_range(0, 9) == 0, $urandom,
                 $urandom_range(0, 59) == 0);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
